// File: rtl/fixed_p_mult_arb_pkg.sv
// Shared types, limits and helper functions for the fixed-point multiplier arbiter.
// Optional feature macro: FIXED_P_MULT_ARB_SAT_EN (see fixed_p_mult_pipe_core).
package fixed_p_mult_arb_pkg;

    localparam int MIN_LATENCY = 2;
    localparam int MAX_REQ     = 32;
    localparam int MAX_W       = 64;

    // One-hot grant of the first set bit at or after ptr, wrapping within num requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 num
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < num && !found) begin
                idx = ptr + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (valid[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

    // Truncating fixed-point slice prod[width+frac-1:frac]; optional saturation on overflow.
    function automatic logic [MAX_W-1:0] fp_slice(
        input logic [2*MAX_W-1:0] prod,
        input int                 width,
        input int                 frac,
        input logic               sat
    );
        logic [MAX_W-1:0] res;
        logic             ovf;
        res = '0;
        ovf = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                res[i] = prod[i+frac];
            end
        end
        for (int i = 0; i < 2*MAX_W; i++) begin
            if (i >= width + frac && i < 2*width) begin
                ovf = ovf | prod[i];
            end
        end
        if (sat && ovf) begin
            for (int i = 0; i < MAX_W; i++) begin
                if (i < width) begin
                    res[i] = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_p_mult_pipe_core.sv
// Valid/tag/data pipeline around one unsigned multiply: operand stage, product stages, slice stage.
// FIXED_P_MULT_ARB_SAT_EN selects saturation instead of truncation in the slice stage.
module fixed_p_mult_pipe_core
    import fixed_p_mult_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int LATENCY    = 3,
    parameter int TAG_W      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vld_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic [WIDTH-1:0] in_left_i,
    input  logic [WIDTH-1:0] in_right_i,
    output logic             out_vld_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);

`ifdef FIXED_P_MULT_ARB_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int MID = LATENCY - 2;

    logic                 vld_p0_q;
    logic [TAG_W-1:0]     tag_p0_q;
    logic [WIDTH-1:0]     left_p0_q;
    logic [WIDTH-1:0]     right_p0_q;
    logic [2*WIDTH-1:0]   left_ext;
    logic [2*WIDTH-1:0]   right_ext;
    logic [2*WIDTH-1:0]   prod_p0;

    logic                 fin_vld;
    logic [TAG_W-1:0]     fin_tag;
    logic [2*WIDTH-1:0]   fin_prod;
    logic                 mid_busy;

    logic [2*MAX_W-1:0]   prod_ext;
    logic [MAX_W-1:0]     slice_full;
    logic [WIDTH-1:0]     res_p2_d;
    logic                 vld_p2_q;
    logic [TAG_W-1:0]     tag_p2_q;
    logic [WIDTH-1:0]     res_p2_q;

    // Stage p0: operands and tag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0_q   <= 1'b0;
            tag_p0_q   <= '0;
            left_p0_q  <= '0;
            right_p0_q <= '0;
        end else begin
            vld_p0_q   <= in_vld_i;
            tag_p0_q   <= in_tag_i;
            left_p0_q  <= in_left_i;
            right_p0_q <= in_right_i;
        end
    end

    assign left_ext  = {{WIDTH{1'b0}}, left_p0_q};
    assign right_ext = {{WIDTH{1'b0}}, right_p0_q};
    assign prod_p0   = left_ext * right_ext;

    // Stage p1: full-width product, LATENCY-2 registers deep
    if (MID > 0) begin : g_mid
        logic               vld_p1_q  [MID];
        logic [TAG_W-1:0]   tag_p1_q  [MID];
        logic [2*WIDTH-1:0] prod_p1_q [MID];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k < MID; k++) begin
                    vld_p1_q[k]  <= 1'b0;
                    tag_p1_q[k]  <= '0;
                    prod_p1_q[k] <= '0;
                end
            end else begin
                vld_p1_q[0]  <= vld_p0_q;
                tag_p1_q[0]  <= tag_p0_q;
                prod_p1_q[0] <= prod_p0;
                for (int k = 1; k < MID; k++) begin
                    vld_p1_q[k]  <= vld_p1_q[k-1];
                    tag_p1_q[k]  <= tag_p1_q[k-1];
                    prod_p1_q[k] <= prod_p1_q[k-1];
                end
            end
        end

        always_comb begin
            mid_busy = 1'b0;
            for (int k = 0; k < MID; k++) begin
                mid_busy = mid_busy | vld_p1_q[k];
            end
        end

        assign fin_vld  = vld_p1_q[MID-1];
        assign fin_tag  = tag_p1_q[MID-1];
        assign fin_prod = prod_p1_q[MID-1];
    end else begin : g_nomid
        assign fin_vld  = vld_p0_q;
        assign fin_tag  = tag_p0_q;
        assign fin_prod = prod_p0;
        assign mid_busy = 1'b0;
    end

    always_comb begin
        prod_ext                = '0;
        prod_ext[2*WIDTH-1:0]   = fin_prod;
        slice_full              = fp_slice(prod_ext, WIDTH, FRAC_WIDTH, SAT_EN);
        res_p2_d                = slice_full[WIDTH-1:0];
    end

    // Stage p2: sliced result; data holds between responses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2_q <= 1'b0;
            tag_p2_q <= '0;
            res_p2_q <= '0;
        end else begin
            vld_p2_q <= fin_vld;
            tag_p2_q <= fin_tag;
            if (fin_vld) begin
                res_p2_q <= res_p2_d;
            end
        end
    end

    assign out_vld_o  = vld_p2_q;
    assign out_tag_o  = tag_p2_q;
    assign out_data_o = res_p2_q;
    assign busy_o     = vld_p0_q | mid_busy | vld_p2_q;

endmodule

// File: rtl/fixed_p_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among NUM_REQ requesters.
// Saturation on overflow is enabled by defining FIXED_P_MULT_ARB_SAT_EN.
module fixed_p_mult_arbiter
    import fixed_p_mult_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_left,
    input  logic [NUM_REQ*WIDTH-1:0] req_right,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_out,
    output logic                     idle
);

    localparam int TAG_W = $clog2(NUM_REQ);

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_chk_fmt
        $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end
    if (LATENCY < MIN_LATENCY) begin : g_chk_lat
        $error("LATENCY must be at least MIN_LATENCY");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_chk_req
        $error("NUM_REQ out of range");
    end
    if (WIDTH > MAX_W) begin : g_chk_w
        $error("WIDTH exceeds MAX_W");
    end

    logic [TAG_W-1:0]   ptr_q;
    logic [TAG_W-1:0]   ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] pick_full;
    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   gnt_tag;
    logic               issue;
    logic [WIDTH-1:0]   issue_left;
    logic [WIDTH-1:0]   issue_right;

    logic               core_vld;
    logic [TAG_W-1:0]   core_tag;
    logic [WIDTH-1:0]   core_data;
    logic               core_busy;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
        pick_full              = rr_pick(valid_ext, int'(ptr_q), NUM_REQ);
        grant                  = reset_n ? pick_full[NUM_REQ-1:0] : '0;
    end

    always_comb begin
        gnt_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_tag = TAG_W'(i);
            end
        end
    end

    assign issue       = |grant;
    assign issue_left  = req_left[gnt_tag*WIDTH +: WIDTH];
    assign issue_right = req_right[gnt_tag*WIDTH +: WIDTH];

    // Pointer moves just past the winner so it drops to lowest priority next cycle
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_tag == TAG_W'(NUM_REQ-1)) ? '0 : gnt_tag + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    fixed_p_mult_pipe_core #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .LATENCY    (LATENCY),
        .TAG_W      (TAG_W)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vld_i   (issue),
        .in_tag_i   (gnt_tag),
        .in_left_i  (issue_left),
        .in_right_i (issue_right),
        .out_vld_o  (core_vld),
        .out_tag_o  (core_tag),
        .out_data_o (core_data),
        .busy_o     (core_busy)
    );

    always_comb begin
        resp_valid = '0;
        if (core_vld) begin
            resp_valid[core_tag] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign resp_out  = core_data;
    assign idle      = ~core_busy & ~issue;

endmodule
